deselect8: RTL and testbench

- Receiving end of the 8-slot time-multiplexed serial link.
- The link transmitter presents a frame marker (start=1) in slot 0, then data bits 1..8 in slots 1..8. Each slot lasts one time_025 period.
- This block uses the same time_025 pulse to rebuild the 8-bit parallel word, flags one-cycle word-valid, and detects framing errors.
- Sits on the far side of the serial wire, feeding the counter/UART logic with a parallel byte.

---
 rtl/deselect8_pkg.sv | 9 +
 rtl/deselect8_if.sv | 13 +
 rtl/deselect8_tick_edge.sv | 20 ++
 rtl/deselect8.sv | 76 +++++++
 tb/tb_deselect8.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/deselect8_pkg.sv
// deselect8_pkg: shared link constants, receiver states and helpers
package deselect8_pkg;
  localparam int SLOT_BITS = 4;
  localparam int NBITS_DEFAULT = 8;
  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/deselect8_if.sv
// deselect8_if: serial link inputs and parallel word outputs of the receiver
interface deselect8_if import deselect8_pkg::*; #(parameter int NBITS = NBITS_DEFAULT) ();
  logic             time_025;
  logic             start;
  logic             in;
  logic [NBITS:1]   out;
  logic             valid;
  logic             busy;
  logic             frame_err;
  logic [7:0]       err_cnt;
  modport slave (input time_025, start, in, output out, valid, busy, frame_err, err_cnt);
  modport master (output time_025, start, in, input out, valid, busy, frame_err, err_cnt);
endinterface

// File: rtl/deselect8_tick_edge.sv
// deselect8_tick_edge: one-cycle pulse on each rising edge of a level input
module deselect8_tick_edge (
  input  logic clk_in,
  input  logic reset,
  input  logic i_level,
  output logic o_pulse
);
  logic r_q1, r_q2;
  // two-flop history of the level; pulse when newest is high and older is low
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_q1 <= 1'b0;
      r_q2 <= 1'b0;
    end else begin
      r_q1 <= i_level;
      r_q2 <= r_q1;
    end
  end
  assign o_pulse = r_q1 & ~r_q2;
endmodule

// File: rtl/deselect8.sv
// deselect8: rebuilds the parallel word from the slot-multiplexed serial link
module deselect8 import deselect8_pkg::*; #(parameter int NBITS = NBITS_DEFAULT) (
  input  logic     clk_in,
  input  logic     reset,
  deselect8_if.slave lnk
);
  localparam logic [SLOT_BITS-1:0] LAST = SLOT_BITS'(NBITS);
  state_t               r_state, w_state;
  logic [SLOT_BITS-1:0] r_idx, w_idx;
  logic [NBITS:1]       r_shift, w_shift, r_out, w_out;
  logic                 r_valid, w_valid, r_ferr, w_ferr, w_tick;
  logic [7:0]           r_cnt, w_cnt;

  deselect8_tick_edge u_tick (
    .clk_in (clk_in),
    .reset  (reset),
    .i_level(lnk.time_025),
    .o_pulse(w_tick)
  );

  // state, slot index, word and pulse registers
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_shift <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_out   <= w_out;
      r_valid <= w_valid;
      r_ferr  <= w_ferr;
      r_cnt   <= w_cnt;
    end
  end

  // only tick cycles advance the frame; a marker while receiving resyncs with an error
  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_out   = r_out;
    w_valid = 1'b0;
    w_ferr  = 1'b0;
    w_cnt   = r_cnt;
    if (w_tick) begin
      if (lnk.start) begin
        w_state = RECV;
        w_idx   = SLOT_BITS'(1);
        w_ferr  = (r_state == RECV);
        w_cnt   = (r_state == RECV) ? sat_inc(r_cnt) : r_cnt;
      end else if (r_state == RECV) begin
        w_shift[r_idx] = lnk.in;
        if (r_idx == LAST) begin
          w_out   = w_shift;
          w_valid = 1'b1;
          w_state = IDLE;
          w_idx   = '0;
        end else begin
          w_idx = r_idx + SLOT_BITS'(1);
        end
      end
    end
  end

  assign lnk.out       = r_out;
  assign lnk.valid     = r_valid;
  assign lnk.busy      = (r_state == RECV);
  assign lnk.frame_err = r_ferr;
  assign lnk.err_cnt   = r_cnt;
endmodule

// File: tb/tb_deselect8.sv
// tb_deselect8: directed link frames checked against a per-tick frame model
module tb_deselect8;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   vt[$];
  int   fe[$];

  deselect8_if #(.NBITS(8)) bus ();
  deselect8 #(.NBITS(8)) dut (.clk_in(clk), .reset(rst_n), .lnk(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // model: frame state, collected bits and expected outputs
  logic       m_busy = 1'b0, m_valid = 1'b0, m_ferr = 1'b0;
  logic [8:1] m_out = '0;
  logic [7:0] m_cnt = '0;
  logic       t1 = 1'b0, t2 = 1'b0;
  logic       q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // a tick is seen at the edge after time_025 was first sampled high
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_ferr = 0; m_out = '0; m_cnt = '0;
      t1 = 0; t2 = 0; q.delete();
    end else begin
      m_valid = 0;
      m_ferr = 0;
      if (t1 && !t2) begin
        if (bus.start) begin
          if (m_busy) begin
            m_ferr = 1;
            m_cnt = (m_cnt == 8'd255) ? m_cnt : m_cnt + 8'd1;
          end
          m_busy = 1;
          q.delete();
        end else if (m_busy) begin
          q.push_back(bus.in);
          if (q.size() == 8) begin
            for (int k = 1; k <= 8; k++) m_out[k] = q[k-1];
            m_valid = 1;
            m_busy = 0;
            q.delete();
          end
        end
      end
      t2 = t1;
      t1 = bus.time_025;
    end
  end

  // every-cycle comparison against the model, plus pulse logging
  always @(negedge clk) begin
    chk("model", {13'd0, bus.out, bus.valid, bus.busy, bus.frame_err, bus.err_cnt},
                 {13'd0, m_out, m_valid, m_busy, m_ferr, m_cnt});
    if (bus.valid) vt.push_back(cyc);
    if (bus.frame_err) fe.push_back(cyc);
  end

  task automatic slot(input logic s, input logic d, input int hi, input int lo);
    bus.start = s;
    bus.in = d;
    bus.time_025 = 1'b1;
    repeat (hi) @(negedge clk);
    bus.time_025 = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] w, input int hi, input int lo);
    slot(1'b1, 1'b0, hi, lo);
    for (int k = 0; k < 8; k++) slot(1'b0, w[k], hi, lo);
  endtask

  function automatic logic [31:0] outs();
    return {13'd0, bus.out, bus.valid, bus.busy, bus.frame_err, bus.err_cnt};
  endfunction

  initial begin
    int n0, f0;
    logic [7:0] w;
    bus.time_025 = 1'b0;
    bus.start = 1'b0;
    bus.in = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", outs(), 32'd0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    n0 = vt.size(); f0 = fe.size();
    repeat (3) frame(8'b1010_0110, 1, 3);
    repeat (4) @(negedge clk);
    chk("loop_valid_count", vt.size() - n0, 3);
    chk("loop_spacing_1", vt[n0+1] - vt[n0], 36);
    chk("loop_spacing_2", vt[n0+2] - vt[n0+1], 36);
    chk("loop_out", bus.out, 8'hA6);
    chk("loop_no_ferr", fe.size() - f0, 0);

    w = 8'hA6;
    #2 rst_n = 1'b0;
    slot(1'b1, 1'b0, 1, 3);
    for (int k = 0; k < 3; k++) slot(1'b0, w[k], 1, 3);
    bus.start = 1'b0; bus.in = w[3]; bus.time_025 = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    n0 = vt.size();
    @(negedge clk);
    bus.time_025 = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 4; k < 8; k++) slot(1'b0, w[k], 1, 3);
    chk("midrst_no_valid", vt.size() - n0, 0);
    frame(8'h3C, 1, 3);
    repeat (3) @(negedge clk);
    chk("midrst_valid_count", vt.size() - n0, 1);
    chk("midrst_out", bus.out, 8'h3C);
    chk("midrst_err_cnt", bus.err_cnt, 0);

    w = 8'h99;
    n0 = vt.size(); f0 = fe.size();
    slot(1'b1, 1'b0, 1, 3);
    for (int k = 0; k < 4; k++) slot(1'b0, w[k], 1, 3);
    slot(1'b1, 1'b0, 1, 3);
    chk("marker_ferr_count", fe.size() - f0, 1);
    chk("marker_err_cnt", bus.err_cnt, 1);
    chk("marker_out_kept", bus.out, 8'h3C);
    chk("marker_no_valid", vt.size() - n0, 0);
    w = 8'hC3;
    for (int k = 0; k < 8; k++) slot(1'b0, w[k], 1, 3);
    repeat (2) @(negedge clk);
    chk("resync_valid", vt.size() - n0, 1);
    chk("resync_out", bus.out, 8'hC3);

    n0 = vt.size();
    frame(8'h5A, 50, 3);
    repeat (3) @(negedge clk);
    chk("long_valid", vt.size() - n0, 1);
    chk("long_out", bus.out, 8'h5A);

    f0 = fe.size();
    repeat (301) slot(1'b1, 1'b0, 1, 2);
    repeat (3) @(negedge clk);
    chk("sat_ferr_count", fe.size() - f0, 300);
    chk("sat_err_cnt", bus.err_cnt, 255);

    w = 8'h81;
    slot(1'b1, 1'b0, 1, 3);
    for (int k = 0; k < 6; k++) slot(1'b0, w[k], 1, 3);
    chk("busy_before_rst", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_outs", outs(), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    n0 = vt.size();
    @(negedge clk);
    for (int k = 6; k < 8; k++) slot(1'b0, w[k], 1, 3);
    chk("after_rst_no_valid", vt.size() - n0, 0);
    frame(8'h81, 1, 3);
    repeat (3) @(negedge clk);
    chk("after_rst_valid", vt.size() - n0, 1);
    chk("after_rst_out", bus.out, 8'h81);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
